// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the BCD stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam logic [3:0] LIM_9 = 4'd9;
  localparam logic [3:0] LIM_5 = 4'd5;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counting 0..MAX; carry is combinational so a whole chain
// resolves on the same edge as the incoming tick.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = LIM_9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = inc && (q == MAX);

  // The >= compare also pulls an out-of-range value back to 0 on the next increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= (q >= MAX) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// Stopwatch core: button synchronisers, start/stop/clear FSM, tick divider
// and a six-digit BCD chain (mm:ss.cc) with a sticky overflow flag.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_clr,
  output logic [3:0] cs_lo,
  output logic [3:0] cs_hi,
  output logic [3:0] s_lo,
  output logic [3:0] s_hi,
  output logic [3:0] m_lo,
  output logic [3:0] m_hi,
  output logic       running,
  output logic       ovf
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [1:0] ss_sync, clr_sync;
  logic       ss_prev, clr_prev;
  logic       ss_edge, clr_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync  <= 2'b00;
      clr_sync <= 2'b00;
      ss_prev  <= 1'b0;
      clr_prev <= 1'b0;
    end else begin
      ss_sync  <= {ss_sync[0], btn_ss};
      clr_sync <= {clr_sync[0], btn_clr};
      ss_prev  <= ss_sync[1];
      clr_prev <= clr_sync[1];
    end
  end

  assign ss_edge  = ss_sync[1] & ~ss_prev;
  assign clr_edge = clr_sync[1] & ~clr_prev;

  sw_state_t state, state_nxt;

  always_comb begin
    state_nxt = state;
    if (clr_edge) begin
      state_nxt = IDLE;
    end else if (ss_edge) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == RUN);
    end
  end

  // Divider keeps its phase across PAUSE so sub-tick time is not lost.
  logic [DW-1:0] div;
  logic          tick;

  assign tick = (state == RUN) && (div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (clr_edge) begin
      div <= '0;
    end else if (state == RUN) begin
      div <= tick ? '0 : div + DW'(1);
    end
  end

  logic c_cs_lo, c_cs_hi, c_s_lo, c_s_hi, c_m_lo, c_m_hi;

  bcd_digit #(.MAX(LIM_9)) u_cs_lo (.clk(clk), .rst_n(rst_n), .clr(clr_edge),
                                    .inc(tick),    .q(cs_lo), .carry(c_cs_lo));
  bcd_digit #(.MAX(LIM_9)) u_cs_hi (.clk(clk), .rst_n(rst_n), .clr(clr_edge),
                                    .inc(c_cs_lo), .q(cs_hi), .carry(c_cs_hi));
  bcd_digit #(.MAX(LIM_9)) u_s_lo  (.clk(clk), .rst_n(rst_n), .clr(clr_edge),
                                    .inc(c_cs_hi), .q(s_lo),  .carry(c_s_lo));
  bcd_digit #(.MAX(LIM_5)) u_s_hi  (.clk(clk), .rst_n(rst_n), .clr(clr_edge),
                                    .inc(c_s_lo),  .q(s_hi),  .carry(c_s_hi));
  bcd_digit #(.MAX(LIM_9)) u_m_lo  (.clk(clk), .rst_n(rst_n), .clr(clr_edge),
                                    .inc(c_s_hi),  .q(m_lo),  .carry(c_m_lo));
  bcd_digit #(.MAX(LIM_5)) u_m_hi  (.clk(clk), .rst_n(rst_n), .clr(clr_edge),
                                    .inc(c_m_lo),  .q(m_hi),  .carry(c_m_hi));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (clr_edge) begin
      ovf <= 1'b0;
    end else if (c_m_hi) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: directed vector table, randomized buttons against
// an elapsed-time reference model, forced preload for the full wrap, async reset.
module tb_stopwatch_bcd;

  localparam int DIV     = 10;
  localparam int FULL    = 360000;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_ss, btn_clr;
  logic [3:0] cs_lo, cs_hi, s_lo, s_hi, m_lo, m_hi;
  logic       running, ovf;
  logic [23:0] dut_digits;

  stopwatch_bcd #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk(clk), .rst_n(rst_n), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .cs_lo(cs_lo), .cs_hi(cs_hi), .s_lo(s_lo), .s_hi(s_hi),
    .m_lo(m_lo), .m_hi(m_hi), .running(running), .ovf(ovf)
  );

  always #5 clk = ~clk;

  assign dut_digits = {m_hi, m_lo, s_hi, s_lo, cs_hi, cs_lo};

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode, cycles of RUN since the last tick, elapsed centiseconds.
  int m_mode, m_phase, m_total;
  bit m_ovf;
  bit prev_ss, prev_clr;
  bit hs[3];
  bit hc[3];

  typedef struct {
    bit ss;
    bit clr;
    int n;
    bit run;
    int total;
    bit ovf;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [23:0] exp_digits(input int t);
    int m, s, c;
    m = t / 6000;
    s = (t / 100) % 60;
    c = t % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_phase = 0; m_total = 0; m_ovf = 0;
    prev_ss = 0; prev_clr = 0;
    for (int i = 0; i < 3; i++) begin
      hs[i] = 0; hc[i] = 0;
    end
  endtask

  task automatic model_edge(input bit s, input bit c);
    if (c) begin
      m_mode = M_IDLE; m_phase = 0; m_total = 0; m_ovf = 0;
    end else begin
      if (m_mode == M_RUN) begin
        m_phase++;
        if (m_phase == DIV) begin
          m_phase = 0;
          m_total++;
          if (m_total == FULL) begin
            m_total = 0;
            m_ovf = 1;
          end
        end
      end
      if (s) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
    end
  endtask

  // Drive buttons for one cycle; a rising level takes effect two edges later.
  task automatic step(input bit ss, input bit clr);
    btn_ss  = ss;
    btn_clr = clr;
    hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = ss & ~prev_ss;
    hc[2] = hc[1]; hc[1] = hc[0]; hc[0] = clr & ~prev_clr;
    prev_ss = ss;
    prev_clr = clr;
    @(posedge clk);
    #1;
    model_edge(hs[2], hc[2]);
    chk("model_digits", dut_digits, exp_digits(m_total));
    chk("model_running", running, (m_mode == M_RUN));
    chk("model_ovf", ovf, m_ovf);
  endtask

  initial begin
    bit cur_ss, cur_clr;

    tbl[0]  = '{0, 0, 100, 0, 0,  0};
    tbl[1]  = '{1, 0, 2,   0, 0,  0};
    tbl[2]  = '{1, 0, 1,   1, 0,  0};
    tbl[3]  = '{1, 0, 47,  1, 4,  0};
    tbl[4]  = '{0, 0, 203, 1, 25, 0};
    tbl[5]  = '{0, 0, 1,   1, 25, 0};
    tbl[6]  = '{1, 0, 3,   0, 25, 0};
    tbl[7]  = '{0, 0, 200, 0, 25, 0};
    tbl[8]  = '{1, 0, 2,   0, 25, 0};
    tbl[9]  = '{1, 0, 1,   1, 25, 0};
    tbl[10] = '{0, 0, 5,   1, 25, 0};
    tbl[11] = '{0, 0, 1,   1, 26, 0};
    tbl[12] = '{1, 1, 2,   1, 26, 0};
    tbl[13] = '{1, 1, 1,   0, 0,  0};
    tbl[14] = '{0, 0, 20,  0, 0,  0};

    rst_n = 1'b0;
    btn_ss = 1'b0;
    btn_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_digits", dut_digits, 24'h0);
    chk("reset_running", running, 0);
    chk("reset_ovf", ovf, 0);

    for (int i = 0; i < 15; i++) begin
      repeat (tbl[i].n) step(tbl[i].ss, tbl[i].clr);
      chk($sformatf("tbl%0d_running", i), running, tbl[i].run);
      chk($sformatf("tbl%0d_digits", i), dut_digits, exp_digits(tbl[i].total));
      chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ovf);
    end

    cur_ss = 0;
    cur_clr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) cur_ss = ~cur_ss;
      if ($urandom_range(0, 199) == 0) cur_clr = ~cur_clr;
      step(cur_ss, cur_clr);
    end

    // Known state, then pause and preload 59:59.99 to exercise the full cascade.
    repeat (2) step(0, 0);
    repeat (3) step(0, 1);
    repeat (2) step(0, 0);
    repeat (3) step(1, 0);
    repeat (7) step(0, 0);
    repeat (3) step(1, 0);
    chk("preload_paused", running, 0);
    m_total = FULL - 1;
    force dut.u_cs_lo.q = 4'd9;
    force dut.u_cs_hi.q = 4'd9;
    force dut.u_s_lo.q  = 4'd9;
    force dut.u_s_hi.q  = 4'd5;
    force dut.u_m_lo.q  = 4'd9;
    force dut.u_m_hi.q  = 4'd5;
    repeat (2) step(0, 0);
    release dut.u_cs_lo.q;
    release dut.u_cs_hi.q;
    release dut.u_s_lo.q;
    release dut.u_s_hi.q;
    release dut.u_m_lo.q;
    release dut.u_m_hi.q;
    step(0, 0);
    chk("preload_held", dut_digits, 24'h595999);
    repeat (3) step(1, 0);
    repeat (15) step(0, 0);
    chk("wrap_ovf", ovf, 1);
    chk("wrap_running", running, 1);
    chk("wrap_upper_digits", {m_hi, m_lo, s_hi, s_lo, cs_hi}, 20'h0);

    // Reset asserted between edges must clear outputs without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_digits", dut_digits, 24'h0);
    chk("async_running", running, 0);
    chk("async_ovf", ovf, 0);
    btn_ss = 1'b0;
    btn_clr = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step(1, 0);
    repeat (30) step(0, 0);
    chk("post_reset_count", dut_digits, exp_digits(3));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Stopwatch core that produces six BCD digits for the board's seven-segment display path: minutes, seconds and centiseconds, range 00:00.00 to 59:59.99. Each 4-bit digit output feeds one `seg_7_out` instance directly. The block contains:
- a tick divider,
- a start/stop/clear control FSM with synchronised button inputs,
- a cascaded BCD counter chain with a sticky overflow flag.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency in Hz.
- `TICK_HZ`, default 100: count rate in Hz (centiseconds). The derived constant DIV = CLK_HZ/TICK_HZ must be ≥ 2.
- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: reset, **asynchronous and active-low**.
- `btn_ss` input 1: start/stop request. Active-high level, asynchronous to `clk`.
- `btn_clr` input 1: clear request. Active-high level, asynchronous to `clk`.
- `cs_lo`, `cs_hi` output 4 each: centisecond digits, 0–9 each.
- `s_lo` output 4: seconds ones digit, 0–9.
- `s_hi` output 4: seconds tens digit, 0–5.
- `m_lo` output 4: minutes ones digit, 0–9.
- `m_hi` output 4: minutes tens digit, 0–5.
- `running` output 1: high while the FSM is in RUN.
- `ovf` output 1: sticky flag, set on wrap from 59:59.99 to 00:00.00.

## Operation
- **Input conditioning:** each button passes through a 2-flop synchroniser and then a rising-edge detector. A held button produces exactly one request.
- **FSM states:** IDLE, RUN, PAUSE.
  - IDLE + ss edge → RUN.
  - RUN + ss edge → PAUSE.
  - PAUSE + ss edge → RUN.
  - A clr edge in any state → IDLE, all digits 0, divider 0, `ovf` 0.
  - If ss and clr edges occur in the same cycle, clr wins.
- **Divider:** counts 0..DIV-1 only in RUN and asserts a one-cycle tick at DIV-1 before returning to 0. In PAUSE it holds its value (not cleared), so sub-tick elapsed time is preserved.
- **BCD chain on tick:**
  - `cs_lo` increments. At 9 it goes to 0 and carries into `cs_hi`.
  - `cs_hi` wraps 9 → 0 and carries into `s_lo`.
  - `s_lo` wraps 9 → 0 and carries into `s_hi`.
  - `s_hi` wraps 5 → 0 and carries into `m_lo`.
  - `m_lo` wraps 9 → 0 and carries into `m_hi`.
  - `m_hi` wraps 5 → 0.
  - All carries resolve in the same cycle as the tick.
- **Wrap:** a carry out of `m_hi` sets `ovf`. Counting continues from 00:00.00 and the FSM stays in RUN.
- **Invariant:** digits never hold values above their limit (9 or 5), in any state or sequence.
- **Reset:** asserting `rst_n` low mid-count forces everything immediately to reset values, with no pending requests kept.

## Timing
- Reset values: all digit outputs 0, `running` 0, `ovf` 0, FSM in IDLE, divider 0, synchroniser and edge registers 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- **Button latency:** `btn_ss` rises before clock edge E0. The synchroniser captures it at E0 and E1, and the FSM state and `running` update at E2.
- **First count:** after entering RUN from IDLE, the first `cs_lo` increment is visible DIV edges after the edge that set `running`.
- **Digit updates:** digits change only on the edge where the divider wraps from DIV-1 to 0.
- **Pause/resume:** after a pause, resuming continues the divider from its held value. The next tick arrives after the remaining count.
- **Clear:** clear latency matches ss latency (effect at E2).

## Structure
- **Shared package** (`stopwatch_pkg`):
  - FSM state enum: IDLE, RUN, PAUSE.
  - Digit limit constants: LIM_9 = 9, LIM_5 = 5.
- **Sub-module** `bcd_digit`:
  - Parameter: MAX.
  - Inputs: `clk`, `rst_n`, `clr`, `inc`.
  - Outputs: 4-bit `q`, `carry`.
  - `carry` is combinational: `inc` AND `q` == MAX.
  - Instantiated six times in a chain.
- **Top level** holds the synchronisers, edge detectors, FSM, divider and `ovf` register.

## Test plan
All scenarios use CLK_HZ = 1000 and TICK_HZ = 100, so DIV = 10.
1. **Reset and idle:** after reset release, no buttons for 100 cycles → all digits 0, `running` 0, `ovf` 0.
2. **Start and count:** one ss pulse, then 250 cycles after `running` rises → `cs_hi:cs_lo` = 25, no other digit nonzero. Holding `btn_ss` for 50 cycles still gives a single start.
3. **Pause and resume:** pause at divider = 4, hold 200 cycles → digits frozen. Resume → next tick after 6 cycles.
4. **Cascade and wrap:** run 360000 ticks (force-preload acceptable) → 59:59.99 rolls to 00:00.00, `ovf` = 1, `running` stays 1.
5. **Clear priority:** ss and clr rise in the same cycle while in RUN → IDLE, digits 0, `ovf` 0, `running` 0.
6. **Async reset:** `rst_n` pulled low mid-RUN between clock edges → outputs go to 0 immediately, without waiting for a clock edge.
